counter_seq_checker: RTL
========================

// Module: counter_seq_checker
// PURPOSE
//  Receive-side checker for the testbench counter stream: samples a free-running
//  up-counter value (e.g. counter_out) on in_valid, locks onto the sequence,
//  checks each sample equals previous + STEP (mod 2^WIDTH), and reports errors.
//  Sits beside the counter in the VPI testbench so Rust/VPI code reads pass/fail
//  from registered status instead of parsing $monitor text.
// PARAMETERS
//  WIDTH        8   width of checked counter value
//  STEP         1   expected increment per valid sample (mod 2^WIDTH)
//  LOSS_THRESH  3   consecutive mismatches that drop lock (>=1)
//  CNT_W        16  width of statistics counters
// PORTS
//  clk               in   1      clock
//  reset             in   1      reset, synchronous, active-high
//  clear             in   1      sync clear of statistics and first-error capture
//  in_valid          in   1      in_data is a counter sample this cycle
//  in_data           in   WIDTH  sampled counter value
//  locked            out  1      checker synchronised to the sequence
//  err_pulse         out  1      one-cycle pulse: previous-cycle sample mismatched
//  sample_count      out  CNT_W  samples checked while LOCKED (saturating)
//  err_count         out  CNT_W  mismatches while LOCKED (saturating)
//  first_err_valid   out  1      first_err_* hold a captured error
//  first_err_exp     out  WIDTH  expected value of first mismatch
//  first_err_act     out  WIDTH  actual value of first mismatch
// BEHAVIOUR
//  - Reset: state HUNT; all outputs 0; expected=0; consec_err=0.
//  - All outputs registered; effects of a sample visible the cycle after in_valid.
//  - in_valid=0: no state, expected or counter change; err_pulse=0.
//  - HUNT: on in_valid, expected<=in_data+STEP, consec_err<=0, -> LOCKED
//    (locked=1 next cycle). Sample not counted, never an error.
//  - LOCKED, in_valid, in_data==expected: sample_count+1, consec_err<=0.
//  - LOCKED, in_valid, mismatch: sample_count+1, err_count+1, err_pulse=1,
//    consec_err+1; if !first_err_valid capture expected/in_data, set valid.
//  - LOCKED, any valid sample: expected<=expected+STEP (no resync on error, so
//    a single corrupt sample costs exactly one error).
//  - Mismatch making consec_err==LOSS_THRESH: -> HUNT, locked<=0, consec_err<=0;
//    counts/capture kept; next valid sample relocks.
//  - Arithmetic: expected wraps mod 2^WIDTH (255+1=0 is a match for WIDTH=8);
//    sample_count/err_count saturate at all-ones, never wrap.
//  - clear: zeroes sample_count, err_count, first_err_*; wins over a same-cycle
//    sample for those registers; state, expected, consec_err and err_pulse
//    still update from that sample normally.
//  - reset mid-stream: reset has priority over everything incl. clear/in_valid.
// TESTING
//  T1 reset, then 258 back-to-back samples 0..255,0,1 -> locked=1 after first,
//     sample_count=257, err_count=0, err_pulse never high (wrap passes).
//  T2 stream 0,1,2,3,9,5,6 -> exactly one err_pulse (cycle after 9), err_count=1,
//     first_err_exp=4, first_err_act=9, locked stays 1.
//  T3 stream 0..3 then 100,101,102,103,104 -> errors on 100,101,102, locked=0
//     after 102, relock on 103, 104 matches; err_count=3, first_err_exp=4/act=100.
//  T4 stream 10,11,12 with 1-4 idle cycles (in_valid=0) between samples, in_data
//     toggling garbage when idle -> no errors, sample_count=2.
//  T5 clear asserted with mismatching sample 20 (expected 7) -> next cycle
//     err_pulse=1, err_count=0, first_err_valid=0; following sample 8 matches.
//  T6 reset mid-stream after T2 -> all outputs 0; stream 50,51 relocks, no error.

Source files
------------

// File: rtl/counter_seq_checker.sv
// Receive-side checker for a free-running counter stream: locks onto the sequence,
// verifies each valid sample equals previous + STEP and keeps registered error statistics.
module counter_seq_checker #(
    parameter int WIDTH       = 8,
    parameter int STEP        = 1,
    parameter int LOSS_THRESH = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_act
);

    localparam int CONS_W = (LOSS_THRESH < 2) ? 1 : $clog2(LOSS_THRESH + 1);
    localparam logic [WIDTH-1:0]  STEP_C    = WIDTH'(STEP);
    localparam logic [CONS_W-1:0] LOSS_M1_C = CONS_W'(LOSS_THRESH - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_expected;
    logic [WIDTH-1:0]   w_nextExpected;
    logic [CONS_W-1:0]  r_consec;
    logic [CONS_W-1:0]  w_nextConsec;
    logic               w_mismatch;
    logic               w_countSample;
    logic               r_errPulse;
    logic [CNT_W-1:0]   r_sampleCount;
    logic [CNT_W-1:0]   r_errCount;
    logic               r_firstValid;
    logic [WIDTH-1:0]   r_firstExp;
    logic [WIDTH-1:0]   r_firstAct;

    assign w_countSample = in_valid && (r_state == LOCKED);

    // The expected value always advances on a locked sample, so one corrupt
    // sample costs exactly one error instead of cascading.
    always_comb begin
        w_nextState    = r_state;
        w_nextExpected = r_expected;
        w_nextConsec   = r_consec;
        w_mismatch     = 1'b0;
        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    w_nextExpected = in_data + STEP_C;
                    w_nextConsec   = '0;
                    w_nextState    = LOCKED;
                end
                LOCKED: begin
                    w_nextExpected = r_expected + STEP_C;
                    if (in_data != r_expected) begin
                        w_mismatch = 1'b1;
                        if (r_consec == LOSS_M1_C) begin
                            w_nextConsec = '0;
                            w_nextState  = HUNT;
                        end else begin
                            w_nextConsec = r_consec + 1'b1;
                        end
                    end else begin
                        w_nextConsec = '0;
                    end
                end
                default: w_nextState = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= HUNT;
            r_expected <= '0;
            r_consec   <= '0;
            r_errPulse <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_expected <= w_nextExpected;
            r_consec   <= w_nextConsec;
            r_errPulse <= w_mismatch;
        end
    end

    // Statistics saturate at all-ones; clear beats a same-cycle sample.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_sampleCount <= '0;
            r_errCount    <= '0;
            r_firstValid  <= 1'b0;
            r_firstExp    <= '0;
            r_firstAct    <= '0;
        end else begin
            if (w_countSample && (r_sampleCount != '1)) begin
                r_sampleCount <= r_sampleCount + 1'b1;
            end
            if (w_mismatch && (r_errCount != '1)) begin
                r_errCount <= r_errCount + 1'b1;
            end
            if (w_mismatch && !r_firstValid) begin
                r_firstValid <= 1'b1;
                r_firstExp   <= r_expected;
                r_firstAct   <= in_data;
            end
        end
    end

    assign locked          = (r_state == LOCKED);
    assign err_pulse       = r_errPulse;
    assign sample_count    = r_sampleCount;
    assign err_count       = r_errCount;
    assign first_err_valid = r_firstValid;
    assign first_err_exp   = r_firstExp;
    assign first_err_act   = r_firstAct;

endmodule
